// File: rtl/bcd_to_bin8.sv
// Sequential 3-digit packed BCD to 8-bit binary converter using reverse double-dabble,
// one right-shift with digit correction per clock behind a start/done handshake.
module bcd_to_bin8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bcd_in,
  output logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  bin_q, bin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  // Shift right, then pull each BCD nibble that reached 8+ back into decimal range.
  function automatic logic [19:0] dabble_step(input logic [19:0] w);
    logic [19:0] s;
    s = w >> 1;
    for (int i = 0; i < 3; i++) begin
      if (s[8+4*i +: 4] >= 4'd8) s[8+4*i +: 4] = s[8+4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

  function automatic logic bad_digit(input logic [11:0] b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_digit(bcd_in)) begin
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            bin_d   = 8'h00;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            work_d  = {bcd_in, 8'h00};
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = dabble_step(work_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          // The BCD field now holds floor(value/256); nonzero means overflow.
          bin_d   = work_d[7:0];
          ovf_d   = |work_d[19:8];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin8.sv
// Directed and randomized bench for bcd_to_bin8 against a decimal-arithmetic reference model.
module tb_bcd_to_bin8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic [7:0]  bin;
  logic        busy, done, ovf, err;

  int checks = 0;
  int failures = 0;

  bcd_to_bin8 dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .bin(bin), .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal value of the three digits.
  task automatic model(input logic [11:0] b, output logic [7:0] eb, output logic eo, output logic ee);
    int v;
    ee = (b[11:8] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
    v  = b[11:8] * 100 + b[7:4] * 10 + b[3:0];
    eb = ee ? 8'h00 : 8'(v % 256);
    eo = ee ? 1'b0 : (v > 255);
  endtask

  // Sample index 0 is the falling edge right after the accepting rising edge.
  task automatic run_conv(input logic [11:0] b, input int poke_at, input string tag);
    logic [7:0] eb;
    logic eo, ee;
    int lat, busyc, donec;
    model(b, eb, eo, ee);
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(posedge clk);
    lat = -1; busyc = 0; donec = 0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; bcd_in = 12'($urandom); end
      if (i == poke_at) begin start = 1'b1; bcd_in = 12'h007; end
      if (i == poke_at + 1) start = 1'b0;
      chk({tag, " busy&done"}, {31'd0, busy & done}, 32'd0);
      if (busy) busyc++;
      if (done) begin lat = i; donec++; end
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, ee ? 0 : 8);
    chk({tag, " busy cycles"}, busyc, ee ? 0 : 8);
    chk({tag, " bin"}, {24'd0, bin}, {24'd0, eb});
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({tag, " err"}, {31'd0, err}, {31'd0, ee});
    @(negedge clk);
    chk({tag, " done width"}, {31'd0, done}, 32'd0);
    chk({tag, " bin hold"}, {24'd0, bin}, {24'd0, eb});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) donec++;
    end
    chk({tag, " single done"}, donec, 1);
  endtask

  initial begin
    logic [7:0] eb;
    logic eo, ee;
    int d1, d2;
    #2;
    chk("rst bin", {24'd0, bin}, 32'd0);
    chk("rst flags", {28'd0, busy, done, ovf, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_conv(12'h255, -1, "c255");

    // Back-to-back with start held: 0x000 then 0x128.
    @(negedge clk);
    bcd_in = 12'h000; start = 1'b1;
    @(posedge clk);
    d1 = -1; d2 = -1;
    for (int i = 0; i < 30 && d2 < 0; i++) begin
      @(negedge clk);
      if (i == 0) bcd_in = 12'h128;
      if (done && d1 < 0) begin
        d1 = i;
        chk("b2b first bin", {24'd0, bin}, 32'h00);
        chk("b2b first ovf", {31'd0, ovf}, 32'd0);
      end else if (done) begin
        d2 = i;
        start = 1'b0;
        chk("b2b second bin", {24'd0, bin}, 32'h80);
        chk("b2b second ovf", {31'd0, ovf}, 32'd0);
      end
    end
    start = 1'b0;
    chk("b2b spacing", d2 - d1, 10);
    repeat (3) @(negedge clk);
    chk("b2b idle after", {31'd0, busy}, 32'd0);

    run_conv(12'h256, -1, "c256");
    run_conv(12'h999, -1, "c999");
    chk("c999 literal bin", {24'd0, bin}, 32'hE7);
    run_conv(12'h1A3, -1, "c1A3");
    run_conv(12'h042, -1, "c042");
    chk("c042 literal bin", {24'd0, bin}, 32'h2A);
    run_conv(12'h100, 3, "c100 poke");
    chk("c100 literal bin", {24'd0, bin}, 32'h64);

    // Asynchronous reset in the middle of a 0x199 conversion.
    @(negedge clk);
    bcd_in = 12'h199; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst bin", {24'd0, bin}, 32'd0);
    chk("midrst flags", {28'd0, busy, done, ovf, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    d1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) d1++;
    end
    chk("no stale activity", d1, 0);
    run_conv(12'h199, -1, "c199");

    for (int k = 0; k < 24; k++) begin
      logic [11:0] b;
      b = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
      run_conv(b, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
